// File: rtl/halflife_sequencer.sv
// Automatic half-life decay sequencer: loads the up/down/load counter, waits one
// half-life period, then halves the counter value with down pulses until it reaches zero.
module halflife_sequencer #(
  parameter int PRESCALE = 1,
  parameter int PER_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       init_val,
  input  logic [PER_W-1:0] period,
  input  logic [3:0]       cnt_val,
  output logic             ctr_load,
  output logic             ctr_up,
  output logic             ctr_down,
  output logic [3:0]       ctr_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       halflives
);

  // state    | meaning
  // ST_IDLE  | waiting for start, no strobes
  // ST_LOAD  | one-cycle load strobe with latched init value
  // ST_SETTLE| counter output settles; zero ends the sequence
  // ST_WAIT  | counting one half-life period in prescaled ticks
  // ST_CALC  | compute the down-pulse count for this halving
  // ST_DECAY | issue the down pulses
  // ST_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SETTLE, ST_WAIT, ST_CALC, ST_DECAY, ST_DONE
  } state_t;

  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  state_t           state, state_nxt;
  logic [3:0]       init_q;
  logic [PER_W-1:0] period_q;
  logic [7:0]       presc;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] per_cnt_nxt;
  logic [3:0]       pending;
  logic [3:0]       halflives_q;
  logic             tick;
  logic             period_hit;

  always_comb begin
    tick        = (presc == PS_LAST);
    per_cnt_nxt = per_cnt + 1'b1;
    period_hit  = tick && (per_cnt_nxt == period_q);
  end

  always_comb begin
    state_nxt = state;
    if (abort && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start && !abort) state_nxt = ST_LOAD;
        ST_LOAD:   state_nxt = ST_SETTLE;
        ST_SETTLE: state_nxt = (cnt_val == 4'd0) ? ST_DONE : ST_WAIT;
        ST_WAIT:   if (period_hit) state_nxt = ST_CALC;
        ST_CALC:   state_nxt = ST_DECAY;
        // pending of 0 would only arise from a counter fault; treat it as the last pulse
        ST_DECAY:  if (pending <= 4'd1) state_nxt = ST_SETTLE;
        ST_DONE:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      init_q      <= '0;
      period_q    <= '0;
      presc       <= '0;
      per_cnt     <= '0;
      pending     <= '0;
      halflives_q <= '0;
    end else begin
      state <= state_nxt;
      if (!abort) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              init_q      <= init_val;
              period_q    <= (period == '0) ? PER_W'(1) : period;
              halflives_q <= '0;
            end
          end
          ST_SETTLE: begin
            presc   <= '0;
            per_cnt <= '0;
          end
          ST_WAIT: begin
            if (tick) begin
              presc   <= '0;
              per_cnt <= per_cnt_nxt;
            end else begin
              presc <= presc + 8'd1;
            end
          end
          ST_CALC: begin
            pending <= (cnt_val == 4'd1) ? 4'd1 : {1'b0, cnt_val[3:1]};
            if (halflives_q != 4'd15) halflives_q <= halflives_q + 4'd1;
          end
          ST_DECAY: pending <= pending - 4'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ctr_load  = (state == ST_LOAD);
    ctr_up    = 1'b0;
    ctr_down  = (state == ST_DECAY);
    ctr_in    = (state == ST_LOAD) ? init_q : 4'd0;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    halflives = halflives_q;
  end

endmodule

// File: tb/tb_halflife_sequencer.sv
// Scoreboard bench: a reference model queues expected load/burst/done events, a
// negedge monitor pops and compares them as the DUTs present strobes.
module tb_halflife_sequencer;

  localparam int K_LOAD = 0, K_BURST = 1, K_DONE = 2;

  typedef struct {
    int kind;
    int val;
    int gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st[2], ab[2];
  logic [3:0] iv[2];
  logic [7:0] per[2];
  logic [3:0] cnt_m[2];
  logic       ld[2], up[2], dn[2], bsy[2], dne[2];
  logic [3:0] cin[2], hl[2];

  exp_t q0[$], q1[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   last[2], bst[2], blen[2];
  bit   inb[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  halflife_sequencer #(.PRESCALE(1), .PER_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .init_val(iv[0]),
    .period(per[0]), .cnt_val(cnt_m[0]), .ctr_load(ld[0]), .ctr_up(up[0]),
    .ctr_down(dn[0]), .ctr_in(cin[0]), .busy(bsy[0]), .done(dne[0]), .halflives(hl[0]));

  halflife_sequencer #(.PRESCALE(4), .PER_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .init_val(iv[1]),
    .period(per[1]), .cnt_val(cnt_m[1]), .ctr_load(ld[1]), .ctr_up(up[1]),
    .ctr_down(dn[1]), .ctr_in(cin[1]), .busy(bsy[1]), .done(dne[1]), .halflives(hl[1]));

  // environment: the 4-bit up/down/load counter each sequencer drives
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (ld[d])      cnt_m[d] <= cin[d];
      else if (dn[d]) cnt_m[d] <= cnt_m[d] - 4'd1;
      else if (up[d]) cnt_m[d] <= cnt_m[d] + 4'd1;
    end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exp(input int d, input int kind, input int val, input int gap);
    exp_t e;
    e.kind = kind; e.val = val; e.gap = gap;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic pop_exp(input int d, output exp_t e);
    e.kind = -1; e.val = -1; e.gap = -1;
    if (d == 0 && q0.size() > 0) e = q0.pop_front();
    else if (d == 1 && q1.size() > 0) e = q1.pop_front();
  endtask

  task automatic mon_step(input int d);
    exp_t e;
    if (ld[d] || dn[d] || up[d]) begin
      chk($sformatf("d%0d_load_down_exclusive", d), int'(ld[d] & dn[d]), 0);
      chk($sformatf("d%0d_up_zero", d), int'(up[d]), 0);
    end
    if (ld[d]) begin
      pop_exp(d, e);
      chk($sformatf("d%0d_load_kind", d), e.kind, K_LOAD);
      chk($sformatf("d%0d_load_value", d), int'(cin[d]), e.val);
      chk($sformatf("d%0d_load_gap", d), cyc - last[d], e.gap);
      last[d] = cyc;
    end
    if (dn[d]) begin
      if (!inb[d]) begin
        inb[d] = 1'b1; bst[d] = cyc; blen[d] = 0;
      end
      blen[d]++;
    end else if (inb[d]) begin
      inb[d] = 1'b0;
      pop_exp(d, e);
      chk($sformatf("d%0d_burst_kind", d), e.kind, K_BURST);
      chk($sformatf("d%0d_burst_len", d), blen[d], e.val);
      chk($sformatf("d%0d_burst_gap", d), bst[d] - last[d], e.gap);
      last[d] = cyc - 1;
    end
    if (dne[d]) begin
      pop_exp(d, e);
      chk($sformatf("d%0d_done_kind", d), e.kind, K_DONE);
      chk($sformatf("d%0d_done_halflives", d), int'(hl[d]), e.val);
      chk($sformatf("d%0d_done_gap", d), cyc - last[d], e.gap);
      chk($sformatf("d%0d_done_counter", d), int'(cnt_m[d]), 0);
      last[d] = cyc;
    end
  endtask

  always @(negedge clk)
    for (int d = 0; d < 2; d++) mon_step(d);

  // reference model: halve v until zero, counting halvings (saturating at 15)
  task automatic expect_seq(input int d, input int v0, input int p, output int h);
    int v, w, b;
    w = ((p == 0) ? 1 : p) * ((d == 0) ? 1 : 4);
    v = v0;
    h = 0;
    push_exp(d, K_LOAD, v0, 1);
    while (v != 0) begin
      b = (v == 1) ? 1 : v / 2;
      push_exp(d, K_BURST, b, 3 + w);
      v = v - b;
      if (h < 15) h++;
    end
    push_exp(d, K_DONE, h, 2);
  endtask

  task automatic pulse_start(input int d, input int v0, input int p);
    iv[d] = 4'(v0); per[d] = 8'(p);
    @(negedge clk);
    st[d] = 1'b1;
    last[d] = cyc;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int limit);
    int n = 0;
    while ((bsy[d] || qsize(d) != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk($sformatf("d%0d_idle_timeout", d), n, 0);
  endtask

  task automatic wait_down(input int d);
    int n = 0;
    while (!dn[d] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk($sformatf("d%0d_down_timeout", d), n, 0);
  endtask

  task automatic run_seq(input int d, input int v0, input int p, input bit poke_wait);
    int h;
    expect_seq(d, v0, p, h);
    pulse_start(d, v0, p);
    if (poke_wait) begin
      repeat (3) @(negedge clk);
      st[d] = 1'b1;
      @(negedge clk);
      st[d] = 1'b0;
    end
    wait_idle(d, 3000);
    @(negedge clk);
    chk($sformatf("d%0d_halflives_hold", d), int'(hl[d]), h);
    chk($sformatf("d%0d_idle_busy", d), int'(bsy[d]), 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; ab[d] = 1'b0; iv[d] = '0; per[d] = '0; cnt_m[d] = '0;
      last[d] = 0; bst[d] = 0; blen[d] = 0; inb[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_outputs", d),
          int'({ld[d], up[d], dn[d], cin[d], bsy[d], dne[d], hl[d]}), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_seq(0, 8, 2, 1'b0);
    run_seq(0, 15, 0, 1'b0);
    run_seq(0, 0, 5, 1'b0);
    run_seq(1, 2, 3, 1'b0);
    run_seq(0, 9, 3, 1'b1);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    st[0] = 1'b1; ab[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0; ab[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("d0_start_abort_idle", int'(bsy[0]), 0);
    end

    // abort in the second cycle of the first 4-cycle burst
    push_exp(0, K_LOAD, 8, 1);
    push_exp(0, K_BURST, 2, 5);
    pulse_start(0, 8, 2);
    wait_down(0);
    @(negedge clk);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("d0_abort_down", int'(dn[0]), 0);
    chk("d0_abort_busy", int'(bsy[0]), 0);
    chk("d0_abort_done", int'(dne[0]), 0);
    chk("d0_abort_halflives", int'(hl[0]), 1);
    repeat (6) @(negedge clk);
    chk("d0_abort_queue", qsize(0), 0);

    // synchronous reset in the middle of a burst
    push_exp(0, K_LOAD, 8, 1);
    push_exp(0, K_BURST, 1, 5);
    pulse_start(0, 8, 2);
    wait_down(0);
    rst = 1'b1;
    @(negedge clk);
    chk("d0_midrst_outputs",
        int'({ld[0], up[0], dn[0], cin[0], bsy[0], dne[0], hl[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("d0_midrst_no_down", int'(dn[0] | bsy[0]), 0);
    end
    chk("d0_midrst_queue", qsize(0), 0);

    for (int i = 0; i < 20; i++) begin
      run_seq(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 5)), 1'b0);
      run_seq(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
